issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl.sv | 130 +++++++++++++
 tb/tb_issue_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// In-order single-issue control for an RV64IM pipeline: register scoreboard,
// RAW-hazard stall, single outstanding mul/div, and an ID holding register.
module issue_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  output logic                   if_ready,
  output logic                   id_valid,
  output logic [31:0]            id_instr,
  input  logic                   ex_ready,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   md_done,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN = 2'd0, RAW_STALL = 2'd1, MD_WAIT = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            pending_q, pending_d;
  logic                   id_valid_q, id_valid_d;
  logic [31:0]            id_instr_q, id_instr_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic        uses_rs1, uses_rs2, writes_rd, is_md;
  logic [31:0] eff_pending;
  logic        hazard, accept;

  assign op  = if_instr[6:0];
  assign rd  = if_instr[11:7];
  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    unique case (op)
      7'b0110011, 7'b0111011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      7'b1100011, 7'b0100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0010011, 7'b0000011,
      7'b0011011, 7'b1100111: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
      7'b0110111, 7'b0010111,
      7'b1101111:             writes_rd = 1'b1;
      default: ;
    endcase
    if (rd == 5'd0) writes_rd = 1'b0;
  end

  assign is_md = ((op == 7'b0110011) || (op == 7'b0111011)) && if_instr[25];

  // A writeback retiring this cycle already resolves its dependency.
  always_comb begin
    eff_pending = pending_q;
    if (wb_valid) eff_pending[wb_rd] = 1'b0;
  end

  assign hazard = (uses_rs1 && eff_pending[rs1]) || (uses_rs2 && eff_pending[rs2]) ||
                  (writes_rd && eff_pending[rd]);

  assign if_ready = (state_q != MD_WAIT) && !hazard && !flush && (!id_valid_q || ex_ready);
  assign accept   = if_valid && if_ready;

  always_comb begin
    state_d = state_q;
    if (accept && is_md) begin
      state_d = MD_WAIT;
    end else begin
      unique case (state_q)
        RUN:       if (if_valid && hazard && !flush) state_d = RAW_STALL;
        RAW_STALL: if (!hazard || flush)             state_d = RUN;
        MD_WAIT:   if (md_done)                      state_d = RUN;
        default:                                     state_d = RUN;
      endcase
    end
  end

  // Set from an accept wins over a same-cycle clear from writeback.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid)             pending_d[wb_rd] = 1'b0;
    if (accept && writes_rd)  pending_d[rd]    = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (accept) begin
      id_valid_d = 1'b1;
      id_instr_d = if_instr;
    end else if (ex_ready) begin
      id_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (if_valid && !if_ready && (stall_q != {STALL_CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      pending_q  <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      stall_q    <= stall_d;
    end
  end

  assign id_valid     = id_valid_q;
  assign id_instr     = id_instr_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: issued instructions are queued as expected
// ID outputs and popped by a monitor on each execute handshake.
module tb_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid, ex_ready, wb_valid, md_done, flush;
  logic [31:0] if_instr;
  logic [4:0]  wb_rd;
  logic        if_ready, id_valid;
  logic [31:0] id_instr;
  logic [15:0] stall_cycles;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  issue_ctrl #(.STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .id_valid(id_valid), .id_instr(id_instr),
    .ex_ready(ex_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .md_done(md_done), .flush(flush), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: every instruction consumed by execute must match.
  always @(negedge clk) begin
    if (reset && id_valid && ex_ready) begin
      if (exp_q.size() == 0) chk("unexpected_issue", id_instr, 32'hxxxxxxxx);
      else chk("issued_instr", id_instr, exp_q.pop_front());
    end
  end

  // One cycle: check if_ready against expectation, optionally record an accept.
  task automatic cyc(input string name, input logic exp_rdy, input logic push);
    @(negedge clk);
    chk(name, {31'd0, if_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (push) exp_q.push_back(if_instr);
    #1;
  endtask

  initial begin
    reset = 1'b0; if_valid = 1'b0; if_instr = '0; ex_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; md_done = 1'b0; flush = 1'b0;
    #2;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // RAW hazard on x5, released by same-cycle writeback
    if_valid = 1'b1; if_instr = 32'h002082B3;            // add x5,x1,x2
    cyc("add_accept", 1'b1, 1'b1);
    if_instr = 32'h40328333;                             // sub x6,x5,x3
    cyc("raw_stall0", 1'b0, 1'b0);
    cyc("raw_stall1", 1'b0, 1'b0);
    chk("raw_state", 32'(dut.state_q), 32'd1);
    chk("raw_stall_cnt", {16'd0, stall_cycles}, 32'd2);
    wb_valid = 1'b1; wb_rd = 5'd5;
    cyc("raw_bypass", 1'b1, 1'b1);
    wb_valid = 1'b0;
    chk("raw_back_run", 32'(dut.state_q), 32'd0);

    // mul/div holds issue until md_done
    if_instr = 32'h022083B3;                             // mul x7,x1,x2
    cyc("mul_accept", 1'b1, 1'b1);
    chk("md_state", 32'(dut.state_q), 32'd2);
    if_instr = 32'h00100513;                             // addi x10,x0,1
    for (int i = 0; i < 10; i++) cyc("md_wait", 1'b0, 1'b0);
    md_done = 1'b1;
    cyc("md_done_cycle", 1'b0, 1'b0);
    md_done = 1'b0;
    chk("md_to_run", 32'(dut.state_q), 32'd0);
    chk("md_stall_cnt", {16'd0, stall_cycles}, 32'd13);
    cyc("post_md_accept", 1'b1, 1'b1);

    // execute backpressure: ID holds, then back-to-back
    ex_ready = 1'b0;
    if_instr = 32'h00200593;                             // addi x11,x0,2
    for (int i = 0; i < 3; i++) begin
      cyc("bp_not_ready", 1'b0, 1'b0);
      chk("bp_id_stable", id_instr, 32'h00100513);
    end
    ex_ready = 1'b1;
    cyc("bp_release", 1'b1, 1'b1);
    if_instr = 32'h00300613;                             // addi x12,x0,3
    cyc("back_to_back", 1'b1, 1'b1);
    chk("bp_stall_cnt", {16'd0, stall_cycles}, 32'd16);

    // accept setting x9 beats same-cycle writeback clearing x9
    if_instr = 32'h00400493; wb_valid = 1'b1; wb_rd = 5'd9; // addi x9,x0,4
    cyc("set_wins_accept", 1'b1, 1'b1);
    wb_valid = 1'b0;
    chk("set_wins_pend9", {31'd0, dut.pending_q[9]}, 32'd1);

    // x0 write never becomes pending; flush kills ID but keeps scoreboard
    if_instr = 32'h00000013;                             // addi x0,x0,0
    cyc("nop_accept", 1'b1, 1'b1);
    chk("pending_vec", dut.pending_q, 32'h00001EC0);
    if_valid = 1'b0; flush = 1'b1; ex_ready = 1'b0;
    cyc("flush_not_ready", 1'b0, 1'b0);
    void'(exp_q.pop_back());                             // killed nop
    flush = 1'b0; ex_ready = 1'b1;
    chk("flush_id_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_pending", dut.pending_q, 32'h00001EC0);

    // reset in the middle of MD_WAIT
    if_valid = 1'b1; if_instr = 32'h022082B3;            // mul x5,x1,x2
    cyc("mul5_accept", 1'b1, 1'b1);
    if_valid = 1'b0;
    cyc("mul5_drain", 1'b0, 1'b0);
    chk("mul5_state", 32'(dut.state_q), 32'd2);
    chk("mul5_pend", {31'd0, dut.pending_q[5]}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_state", 32'(dut.state_q), 32'd0);
    chk("midrst_pending", dut.pending_q, 32'd0);
    chk("midrst_stall", {16'd0, stall_cycles}, 32'd0);
    chk("midrst_id_valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
